// File: rtl/par_collector.sv
// rtl/par_collector.sv - request/wait/capture collector assembling NIBBLES nibbles into one word
// Optional sequence checker is compiled in when SEQ_CHECK_EN is defined.

module par_collector #(
    parameter int NIBBLES  = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3:0]           data,
    output logic                 ask_for_data,
    output logic [4*NIBBLES-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 seq_err
);

    localparam int AW = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT,
        OUT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    wait_cnt;
    logic [CW-1:0] nib_cnt;
    logic [AW-1:0] asm_reg;
    logic [AW-1:0] asm_nx;
    logic          last_nib;

    assign last_nib = (nib_cnt == CW'(NIBBLES - 1));
    assign asm_nx   = (asm_reg << 4) | AW'(data);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (en) state_nx = REQ;
            REQ:  state_nx = WAIT;
            WAIT: if (wait_cnt == 4'd0) state_nx = CAPT;
            CAPT: state_nx = last_nib ? OUT : REQ;
            OUT:  if (word_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pulse is the registered image of REQ, so it never depends on en combinationally.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            ask_for_data <= 1'b0;
        end else begin
            ask_for_data <= (state == REQ);
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
            nib_cnt  <= '0;
            asm_reg  <= '0;
        end else begin
            case (state)
                REQ:  wait_cnt <= 4'(WAIT_CYC - 1);
                WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                CAPT: begin
                    asm_reg <= asm_nx;
                    nib_cnt <= nib_cnt + CW'(1);
                end
                OUT:  if (word_ready) nib_cnt <= '0;
                default: ;
            endcase
        end
    end

    // word_out only changes when a full word is loaded; partial assembly stays internal.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (state == CAPT && last_nib) begin
            word_out   <= asm_nx;
            word_valid <= 1'b1;
        end else if (state == OUT && word_ready) begin
            word_valid <= 1'b0;
        end
    end

`ifdef SEQ_CHECK_EN
    logic [3:0] prev_nib;
    logic       hist_valid;
    logic       seq_err_r;

    // History survives word boundaries; only reset forgets it.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            prev_nib   <= 4'd0;
            hist_valid <= 1'b0;
            seq_err_r  <= 1'b0;
        end else if (state == CAPT) begin
            prev_nib   <= data;
            hist_valid <= 1'b1;
            if (hist_valid && data != (prev_nib + 4'd1)) seq_err_r <= 1'b1;
        end
    end

    assign seq_err = seq_err_r;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_par_collector.sv
// tb/tb_par_collector.sv - randomized self-checking bench for par_collector with a queue-based reference model

module tb_par_collector;

    localparam int N = 4;
    localparam int W = 2;
`ifdef SEQ_CHECK_EN
    localparam logic EXP_SEQ = 1'b1;
`else
    localparam logic EXP_SEQ = 1'b0;
`endif

    logic          sclk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    data;
    logic          ask_for_data;
    logic [4*N-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic          seq_err;

    logic          en2;
    logic [3:0]    data2;
    logic          ask2;
    logic [7:0]    wo2;
    logic          valid2;
    logic          ready2;
    logic          seq2;

    par_collector #(.NIBBLES(N), .WAIT_CYC(W)) dut (
        .sclk(sclk), .rst(rst), .en(en), .data(data),
        .ask_for_data(ask_for_data), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .seq_err(seq_err)
    );

    par_collector #(.NIBBLES(2), .WAIT_CYC(1)) dut2 (
        .sclk(sclk), .rst(rst), .en(en2), .data(data2),
        .ask_for_data(ask2), .word_out(wo2), .word_valid(valid2),
        .word_ready(ready2), .seq_err(seq2)
    );

    always #5 sclk = ~sclk;

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         words_seen = 0;
    int         asks_seen = 0;
    int         cur_first = 0;
    int         last_ask = 0;
    logic [3:0] gen_next;
    bit         gen_skip;
    bit         rand_ready;
    logic [15:0] last_word;
    logic [3:0]  nib_q[$];
    logic [15:0] exp_words[$];
    int          exp_first[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: generator reacts to each request pulse; model predicts words and timing.
    task automatic tick();
        logic        hs_pre;
        logic        valid_pre;
        logic [15:0] wo_pre;
        logic [15:0] w;
        hs_pre    = word_valid && word_ready;
        valid_pre = word_valid;
        wo_pre    = word_out;
        @(posedge sclk);
        #1;
        cyc++;
        if (ask_for_data) begin
            if (gen_skip) begin
                gen_next = gen_next + 4'd1;
                gen_skip = 1'b0;
            end
            data = gen_next;
            gen_next = gen_next + 4'd1;
            asks_seen++;
            if (nib_q.size() == 0) cur_first = cyc;
            else chk("ask_spacing", 32'(cyc - last_ask), W + 2);
            last_ask = cyc;
            nib_q.push_back(data);
            if (nib_q.size() == N) begin
                w = 16'h0;
                foreach (nib_q[i]) w = (w << 4) | 16'(nib_q[i]);
                exp_words.push_back(w);
                exp_first.push_back(cur_first);
                nib_q.delete();
            end
        end
        if (valid_pre && !hs_pre) begin
            chk("stall_valid", 32'(word_valid), 1);
            chk("stall_word", 32'(word_out), 32'(wo_pre));
            chk("stall_no_ask", 32'(ask_for_data), 0);
        end else if (word_valid) begin
            words_seen++;
            last_word = word_out;
            chk("word_pending", 32'(exp_words.size() > 0), 1);
            if (exp_words.size() > 0) begin
                chk("word_out", 32'(word_out), 32'(exp_words.pop_front()));
                chk("valid_latency", 32'(cyc - exp_first.pop_front()), N * (W + 2) - 1);
            end
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int start;
        int k;
        start = words_seen;
        k = 0;
        while (words_seen - start < n && k < budget) begin
            if (rand_ready) word_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("wait_words_done", 32'(words_seen - start >= n), 1);
    endtask

    task automatic wait_nibs(input int n, input int budget);
        int k;
        k = 0;
        while (!(ask_for_data && nib_q.size() == n) && k < budget) begin
            tick();
            k++;
        end
        chk("wait_nibs_done", 32'(ask_for_data && nib_q.size() == n), 1);
    endtask

    initial begin
        int k;
        int asks_before;
        int c2;
        int first2;
        int last2;
        bit got2;
        logic [3:0] g2;

        rst = 1'b0; en = 1'b0; word_ready = 1'b1; data = 4'h0;
        en2 = 1'b0; data2 = 4'h0; ready2 = 1'b1;
        gen_next = 4'h0; gen_skip = 1'b0; rand_ready = 1'b0; last_word = 16'h0;

        // Reset state
        tick();
        tick();
        chk("rst_ask", 32'(ask_for_data), 0);
        chk("rst_valid", 32'(word_valid), 0);
        chk("rst_word", 32'(word_out), 0);
        chk("rst_seq", 32'(seq_err), 0);
        #2 rst = 1'b1;

        // Free-running collection, counting generator
        en = 1'b1;
        wait_words(5, 200);
        chk("fifth_word", 32'(last_word), 32'h0123);
        chk("seq_clean", 32'(seq_err), 0);

        // Directed backpressure: five stalled cycles at word_valid
        word_ready = 1'b0;
        k = 0;
        while (!word_valid && k < 40) begin
            tick();
            k++;
        end
        chk("stall_reached", 32'(word_valid), 1);
        repeat (5) tick();
        word_ready = 1'b1;
        wait_words(1, 60);

        // Random backpressure
        rand_ready = 1'b1;
        wait_words(6, 800);
        rand_ready = 1'b0;
        word_ready = 1'b1;

        // Reset after two nibbles captured
        wait_nibs(3, 60);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ask", 32'(ask_for_data), 0);
        chk("midrst_valid", 32'(word_valid), 0);
        chk("midrst_word", 32'(word_out), 0);
        nib_q.delete();
        exp_words.delete();
        exp_first.delete();
        gen_next = 4'h0;
        data = 4'h0;
        tick();
        #2 rst = 1'b1;

        k = 0;
        do begin
            tick();
            k++;
        end while (!ask_for_data && k < 10);
        chk("first_ask_seen", 32'(ask_for_data), 1);
        chk("first_ask_not_early", 32'(k >= 2), 1);

        // en dropped during nibble 2: word completes, then silence
        wait_nibs(2, 20);
        en = 1'b0;
        wait_words(1, 60);
        chk("post_rst_word", 32'(last_word), 32'h0123);
        asks_before = asks_seen;
        repeat (40) tick();
        chk("no_ask_after_en_drop", 32'(asks_seen - asks_before), 0);
        chk("idle_valid", 32'(word_valid), 0);

        // Sequence break inside a word
        en = 1'b1;
        wait_nibs(2, 20);
        gen_skip = 1'b1;
        wait_words(3, 200);
        en = 1'b0;
        chk("seq_err_sticky", 32'(seq_err), 32'(EXP_SEQ));
        repeat (3) tick();
        chk("seq_err_held", 32'(seq_err), 32'(EXP_SEQ));

        // Small configuration: NIBBLES=2, WAIT_CYC=1
        en2 = 1'b1;
        g2 = 4'h0;
        c2 = 0;
        first2 = -1;
        last2 = 0;
        got2 = 1'b0;
        repeat (40) begin
            @(posedge sclk);
            #1;
            c2++;
            if (ask2) begin
                if (first2 < 0) first2 = c2;
                else chk("ask2_spacing", 32'(c2 - last2), 3);
                last2 = c2;
                data2 = g2;
                g2 = g2 + 4'd1;
            end
            if (valid2 && !got2) begin
                got2 = 1'b1;
                chk("word2", 32'(wo2), 32'h01);
                chk("latency2", 32'(c2 - first2), 5);
                en2 = 1'b0;
            end
        end
        chk("word2_seen", 32'(got2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
